// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: runs one Zicsr instruction through fixed READ, WRITE and RESP cycles
// against a CSR file with a combinational read port and an edge-registered write port.
module csr_access_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_src,
  input  logic [4:0]      req_zimm,
  input  logic            req_rs1_zero,
  input  logic            req_rd_zero,
  output logic            csr_rd_ena,
  output logic [11:0]     csr_rd_addr,
  input  logic [XLEN-1:0] csr_rd_data,
  output logic            csr_wr_ena,
  output logic [11:0]     csr_wr_addr,
  output logic [XLEN-1:0] csr_wr_data,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_illegal
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e          state_q, state_d;
  logic [1:0]      kind_q, kind_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] operand_q, operand_d;
  logic [XLEN-1:0] old_q, old_d;
  logic            do_rd_q, do_rd_d;
  logic            do_wr_q, do_wr_d;
  logic            illegal_q, illegal_d;

  logic            is_rw, op_valid, src_zero, dec_rd, dec_wr, dec_ill, accept;
  logic [XLEN-1:0] operand_in;

  // funct3[1:0] selects write/set/clear; funct3[2] selects the immediate form.
  assign is_rw      = (req_op[1:0] == 2'b01);
  assign op_valid   = (req_op[1:0] != 2'b00);
  assign operand_in = req_op[2] ? {{(XLEN-5){1'b0}}, req_zimm} : req_src;
  assign src_zero   = req_op[2] ? (req_zimm == 5'd0) : req_rs1_zero;
  assign dec_rd     = !(is_rw && req_rd_zero);
  assign dec_wr     = is_rw || (op_valid && !src_zero);
  assign dec_ill    = !op_valid || (dec_wr && (req_addr[11:10] == 2'b11));

  // Gated by rst so the block never advertises readiness while held in reset.
  assign req_ready  = rst && (state_q == IDLE);
  assign accept     = req_valid && req_ready;

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    addr_d       = addr_q;
    operand_d    = operand_q;
    old_d        = old_q;
    do_rd_d      = do_rd_q;
    do_wr_d      = do_wr_q;
    illegal_d    = illegal_q;
    csr_rd_ena   = 1'b0;
    csr_rd_addr  = '0;
    csr_wr_ena   = 1'b0;
    csr_wr_addr  = '0;
    csr_wr_data  = '0;
    resp_valid   = 1'b0;
    resp_data    = '0;
    resp_illegal = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = READ;
          kind_d    = req_op[1:0];
          addr_d    = req_addr;
          operand_d = operand_in;
          do_rd_d   = dec_rd && !dec_ill;
          do_wr_d   = dec_wr && !dec_ill;
          illegal_d = dec_ill;
        end
      end
      READ: begin
        csr_rd_ena  = do_rd_q;
        csr_rd_addr = do_rd_q ? addr_q : 12'd0;
        old_d       = do_rd_q ? csr_rd_data : '0;
        state_d     = WRITE;
      end
      WRITE: begin
        csr_wr_ena  = do_wr_q;
        csr_wr_addr = do_wr_q ? addr_q : 12'd0;
        if (do_wr_q) begin
          case (kind_q)
            2'b10:   csr_wr_data = old_q | operand_q;
            2'b11:   csr_wr_data = old_q & ~operand_q;
            default: csr_wr_data = operand_q;
          endcase
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid   = 1'b1;
        resp_data    = old_q;
        resp_illegal = illegal_q;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      kind_q    <= 2'b00;
      addr_q    <= 12'd0;
      operand_q <= '0;
      old_q     <= '0;
      do_rd_q   <= 1'b0;
      do_wr_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      addr_q    <= addr_d;
      operand_q <= operand_d;
      old_q     <= old_d;
      do_rd_q   <= do_rd_d;
      do_wr_q   <= do_wr_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: small CSR file model (misa, mscratch, free-running mcycle)
// with a scoreboard of expected responses popped at each response handshake.
module tb_csr_access_ctrl;
  localparam logic [63:0] MISA = 64'h8000_0000_0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_op = 3'b0;
  logic [11:0] req_addr = 12'h0;
  logic [63:0] req_src = 64'h0;
  logic [4:0]  req_zimm = 5'h0;
  logic        req_rs1_zero = 1'b0, req_rd_zero = 1'b0;
  logic        csr_rd_ena, csr_wr_ena;
  logic [11:0] csr_rd_addr, csr_wr_addr;
  logic [63:0] csr_rd_data, csr_wr_data;
  logic        resp_valid, resp_ready = 1'b0, resp_illegal;
  logic [63:0] resp_data;

  always #5 clk = ~clk;

  csr_access_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_src(req_src), .req_zimm(req_zimm),
    .req_rs1_zero(req_rs1_zero), .req_rd_zero(req_rd_zero),
    .csr_rd_ena(csr_rd_ena), .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data),
    .csr_wr_ena(csr_wr_ena), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_illegal(resp_illegal)
  );

  // CSR file model: misa read-only, mscratch plain, mcycle counts unless written.
  logic [63:0] mscratch_m = 64'h0123_4567_89AB_CDEF;
  logic [63:0] mcycle_m   = 64'd1000;
  always @(posedge clk) begin
    if (csr_wr_ena && csr_wr_addr == 12'hB00) mcycle_m <= csr_wr_data;
    else mcycle_m <= mcycle_m + 64'd1;
    if (csr_wr_ena && csr_wr_addr == 12'h340) mscratch_m <= csr_wr_data;
  end
  always_comb begin
    csr_rd_data = 64'h0;
    case (csr_rd_addr)
      12'h301: csr_rd_data = MISA;
      12'h340: csr_rd_data = mscratch_m;
      12'hB00: csr_rd_data = mcycle_m;
      default: csr_rd_data = 64'h0;
    endcase
  end

  // Monitor: edge index, enable pulses, response rise, protocol violations.
  int          cyc = 0, rd_total = 0, wr_total = 0, viol = 0;
  int          rd_cyc = -1, wr_cyc = -1, resp_cyc = -1;
  logic [63:0] last_wdata = 64'h0;
  logic        resp_prev = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (csr_rd_ena) begin rd_total <= rd_total + 1; rd_cyc <= cyc; end
    if (csr_wr_ena) begin wr_total <= wr_total + 1; wr_cyc <= cyc; last_wdata <= csr_wr_data; end
    if (resp_valid && !resp_prev) resp_cyc <= cyc;
    resp_prev <= resp_valid;
    if ((csr_rd_ena && csr_wr_ena) || (!csr_rd_ena && csr_rd_addr != 12'h0) ||
        (!csr_wr_ena && (csr_wr_addr != 12'h0 || csr_wr_data != 64'h0)) ||
        (!resp_valid && (resp_data != 64'h0 || resp_illegal)))
      viol <= viol + 1;
  end

  typedef struct {
    logic [63:0] data; logic ill; logic rd; logic wr; logic [63:0] wdata;
  } exp_t;
  typedef struct {
    logic [63:0] data; logic ill; int rd; int wr; logic [63:0] wdata;
    int rd_lat; int wr_lat; int resp_lat; logic timeout;
  } obs_t;
  typedef struct {
    logic [2:0] op; logic [11:0] addr; logic [63:0] src; logic [4:0] zimm;
    logic rs1z; logic rdz; logic [63:0] data; logic ill; logic rd; logic wr; logic [63:0] wdata;
  } ent_t;

  exp_t sb[$];
  int   n_checks = 0, n_fail = 0;
  int   acc_cyc = 0, rd_base = 0, wr_base = 0;

  // Drive one request at a negedge with the block idle; returns just after the accept edge.
  task automatic send(input logic [2:0] op, input logic [11:0] addr, input logic [63:0] src,
                      input logic [4:0] zimm, input logic rs1z, input logic rdz, input exp_t e);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_src = src;
    req_zimm = zimm; req_rs1_zero = rs1z; req_rd_zero = rdz;
    sb.push_back(e);
    rd_base = rd_total; wr_base = wr_total;
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for the response, take it immediately, report what was observed.
  task automatic collect(output obs_t o);
    o.timeout = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (resp_valid === 1'b1) begin o.timeout = 1'b0; break; end
      @(negedge clk);
    end
    o.data = resp_data; o.ill = resp_illegal;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    o.rd = rd_total - rd_base; o.wr = wr_total - wr_base; o.wdata = last_wdata;
    o.rd_lat = rd_cyc - acc_cyc; o.wr_lat = wr_cyc - acc_cyc; o.resp_lat = resp_cyc - acc_cyc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || csr_rd_ena !== 1'b0 || csr_wr_ena !== 1'b0 ||
        resp_data !== 64'h0 || csr_wr_data !== 64'h0 || resp_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b rv=%b rd=%b wr=%b expected all 0",
               req_ready, resp_valid, csr_rd_ena, csr_wr_ena);
    end
    rst = 1'b1; #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
    @(negedge clk);
  endtask

  task automatic test_ops();
    ent_t t[14];
    exp_t e;
    obs_t o;
    t[0]  = '{3'b010, 12'h301, 64'h0, 5'd0, 1'b1, 1'b0, MISA, 1'b0, 1'b1, 1'b0, 64'h0};
    t[1]  = '{3'b101, 12'hF11, 64'h0, 5'd3, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0};
    t[2]  = '{3'b010, 12'hF11, 64'h0, 5'd0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0};
    t[3]  = '{3'b000, 12'h340, 64'h77, 5'd0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0};
    t[4]  = '{3'b100, 12'h301, 64'h0, 5'd9, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0};
    t[5]  = '{3'b010, 12'h340, 64'hF0, 5'd0, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 1'b1, 64'h0123_4567_89AB_CDFF};
    t[6]  = '{3'b011, 12'h340, 64'h0F00_0000_0000_0000, 5'd0, 1'b0, 1'b0, 64'h0123_4567_89AB_CDFF, 1'b0, 1'b1, 1'b1, 64'h0023_4567_89AB_CDFF};
    t[7]  = '{3'b001, 12'h340, 64'hDEAD_BEEF_0000_0000, 5'd0, 1'b0, 1'b1, 64'h0, 1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0000};
    t[8]  = '{3'b110, 12'h340, 64'h0, 5'd5, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_0000, 1'b0, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0005};
    t[9]  = '{3'b111, 12'h340, 64'h0, 5'd1, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_0005, 1'b0, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0004};
    t[10] = '{3'b010, 12'h340, 64'hFF, 5'd0, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0004, 1'b0, 1'b1, 1'b0, 64'h0};
    t[11] = '{3'b110, 12'hC00, 64'h0, 5'd0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0};
    t[12] = '{3'b110, 12'hC00, 64'h0, 5'd1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0};
    t[13] = '{3'b001, 12'h340, 64'h55, 5'd0, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_0004, 1'b0, 1'b1, 1'b1, 64'h55};
    for (int i = 0; i < 14; i++) begin
      e = '{t[i].data, t[i].ill, t[i].rd, t[i].wr, t[i].wdata};
      send(t[i].op, t[i].addr, t[i].src, t[i].zimm, t[i].rs1z, t[i].rdz, e);
      collect(o);
      e = sb.pop_front();
      n_checks++;
      if (o.timeout !== 1'b0) begin n_fail++; $display("FAIL ops[%0d] resp_timeout: no resp_valid within bound", i); end
      n_checks++;
      if (o.data !== e.data) begin n_fail++; $display("FAIL ops[%0d] resp_data: got %h expected %h", i, o.data, e.data); end
      n_checks++;
      if (o.ill !== e.ill) begin n_fail++; $display("FAIL ops[%0d] resp_illegal: got %b expected %b", i, o.ill, e.ill); end
      n_checks++;
      if (o.rd !== int'(e.rd)) begin n_fail++; $display("FAIL ops[%0d] rd_pulses: got %0d expected %0d", i, o.rd, e.rd); end
      n_checks++;
      if (o.wr !== int'(e.wr)) begin n_fail++; $display("FAIL ops[%0d] wr_pulses: got %0d expected %0d", i, o.wr, e.wr); end
      n_checks++;
      if (o.resp_lat !== 2) begin n_fail++; $display("FAIL ops[%0d] resp_latency: got %0d expected 2", i, o.resp_lat); end
      if (e.rd) begin
        n_checks++;
        if (o.rd_lat !== 0) begin n_fail++; $display("FAIL ops[%0d] rd_cycle: got %0d expected 0", i, o.rd_lat); end
      end
      if (e.wr) begin
        n_checks++;
        if (o.wdata !== e.wdata) begin n_fail++; $display("FAIL ops[%0d] wr_data: got %h expected %h", i, o.wdata, e.wdata); end
        n_checks++;
        if (o.wr_lat !== 1) begin n_fail++; $display("FAIL ops[%0d] wr_cycle: got %0d expected 1", i, o.wr_lat); end
      end
    end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL ops protocol_violations: got %0d expected 0", viol); end
  endtask

  task automatic test_mcycle();
    exp_t e;
    obs_t o;
    int   acc1;
    e = '{mcycle_m + 64'd1, 1'b0, 1'b1, 1'b1, 64'h10};
    send(3'b001, 12'hB00, 64'h10, 5'd0, 1'b0, 1'b0, e);
    acc1 = acc_cyc;
    collect(o);
    e = sb.pop_front();
    n_checks++;
    if (o.data !== e.data) begin n_fail++; $display("FAIL mcycle_rw old: got %h expected %h", o.data, e.data); end
    n_checks++;
    if (o.wr !== 1 || o.wdata !== 64'h10 || o.wr_lat !== 1) begin
      n_fail++; $display("FAIL mcycle_rw write: got n=%0d data=%h lat=%0d expected 1/10/1", o.wr, o.wdata, o.wr_lat);
    end
    // Written at edge acc1+2; read value after the next accept edge counts on from 0x10.
    e = '{64'h10 + 64'(cyc + 1 - (acc1 + 2)), 1'b0, 1'b1, 1'b0, 64'h0};
    send(3'b010, 12'hB00, 64'h0, 5'd0, 1'b1, 1'b0, e);
    collect(o);
    e = sb.pop_front();
    n_checks++;
    if (o.data !== e.data) begin n_fail++; $display("FAIL mcycle_reread: got %h expected %h", o.data, e.data); end
    e = '{mcycle_m + 64'd1, 1'b0, 1'b1, 1'b0, 64'h0};
    send(3'b111, 12'hB00, 64'h0, 5'd0, 1'b0, 1'b0, e);
    collect(o);
    e = sb.pop_front();
    n_checks++;
    if (o.data !== e.data || o.wr !== 0 || o.rd !== 1) begin
      n_fail++; $display("FAIL csrrci_zero: got data=%h rd=%0d wr=%0d expected %h/1/0", o.data, o.rd, o.wr, e.data);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    obs_t        o;
    logic [63:0] d0;
    logic        i0, to, stable, rl, rb;
    e = '{MISA, 1'b0, 1'b1, 1'b0, 64'h0};
    send(3'b010, 12'h301, 64'h0, 5'd0, 1'b1, 1'b0, e);
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (resp_valid === 1'b1) begin to = 1'b0; break; end
      @(negedge clk);
    end
    d0 = resp_data; i0 = resp_illegal; stable = 1'b1; rl = 1'b1;
    req_valid = 1'b1; req_op = 3'b001; req_addr = 12'h340; req_src = 64'hA5A5_A5A5_A5A5_A5A5;
    req_zimm = 5'd0; req_rs1_zero = 1'b0; req_rd_zero = 1'b0;
    sb.push_back('{mscratch_m, 1'b0, 1'b1, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5});
    repeat (5) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== d0 || resp_illegal !== i0) stable = 1'b0;
      if (req_ready !== 1'b0) rl = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    rb = req_ready;
    rd_base = rd_total; wr_base = wr_total;
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (to !== 1'b0 || d0 !== e.data || i0 !== e.ill) begin
      n_fail++; $display("FAIL bp_first: got to=%b data=%h ill=%b expected 0/%h/%b", to, d0, i0, e.data, e.ill);
    end
    n_checks++;
    if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %b expected 1", stable); end
    n_checks++;
    if (rl !== 1'b1) begin n_fail++; $display("FAIL bp_ready_low: got %b expected 1", rl); end
    n_checks++;
    if (rb !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_hs: got %b expected 1", rb); end
    collect(o);
    e = sb.pop_front();
    n_checks++;
    if (o.data !== e.data || o.rd_lat !== 0 || o.wdata !== e.wdata || o.wr !== 1) begin
      n_fail++; $display("FAIL b2b_second: got data=%h rdlat=%0d wdata=%h wr=%0d expected %h/0/%h/1",
                         o.data, o.rd_lat, o.wdata, o.wr, e.data, e.wdata);
    end
  endtask

  task automatic test_reset_mid();
    exp_t        e;
    obs_t        o;
    logic [63:0] m0;
    logic        quiet;
    m0 = mscratch_m;
    send(3'b001, 12'h340, 64'h5555, 5'd0, 1'b0, 1'b0, '{m0, 1'b0, 1'b1, 1'b1, 64'h5555});
    @(posedge clk); #1;
    n_checks++;
    if (csr_wr_ena !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_write: got wr_ena=%b expected 1", csr_wr_ena); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (csr_wr_ena !== 1'b0 || csr_wr_data !== 64'h0 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async_clear: got wr=%b data=%h ready=%b rv=%b expected 0/0/0/0",
                         csr_wr_ena, csr_wr_data, req_ready, resp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", req_ready); end
    n_checks++;
    if (mscratch_m !== m0) begin n_fail++; $display("FAIL rstmid_no_write: got %h expected %h", mscratch_m, m0); end
    void'(sb.pop_front());
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (quiet !== 1'b1) begin n_fail++; $display("FAIL rstmid_resp_dropped: got %b expected 1", quiet); end
    send(3'b010, 12'h340, 64'h0, 5'd0, 1'b1, 1'b0, '{m0, 1'b0, 1'b1, 1'b0, 64'h0});
    collect(o);
    e = sb.pop_front();
    n_checks++;
    if (o.timeout !== 1'b0 || o.data !== e.data || o.wr !== 0) begin
      n_fail++; $display("FAIL rstmid_recover: got to=%b data=%h wr=%0d expected 0/%h/0", o.timeout, o.data, o.wr, e.data);
    end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL final protocol_violations: got %0d expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_mcycle();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
